// File: rtl/sat_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sat_cmd_sequencer_if
// Brief    : Host command/response channels and solver bus of the sequencer.
// Revision : 1.0
// ============================================================================
interface sat_cmd_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_cmd;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] in_c;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_kind;
    logic [7:0] rsp_data;
    logic       busy;
    logic [7:0] s_cmd;
    logic [7:0] s_a;
    logic [7:0] s_b;
    logic [7:0] s_c;
    logic       s_sat;
    logic       s_unsat;
    logic [7:0] s_exbus;

    modport slave (
        input  in_valid, in_cmd, in_a, in_b, in_c, rsp_ready, s_sat, s_unsat, s_exbus,
        output in_ready, rsp_valid, rsp_kind, rsp_data, busy, s_cmd, s_a, s_b, s_c
    );

    modport master (
        output in_valid, in_cmd, in_a, in_b, in_c, rsp_ready, s_sat, s_unsat, s_exbus,
        input  in_ready, rsp_valid, rsp_kind, rsp_data, busy, s_cmd, s_a, s_b, s_c
    );
endinterface
`default_nettype wire

// File: rtl/sat_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sat_cmd_sequencer
// Brief    : Queues host commands and issues them to the SAT solver core,
//            sequencing EVAL/EXTRACT and returning one response word each.
// Revision : 1.0
// ============================================================================
module sat_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int RD_LAT  = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sat_cmd_sequencer_if.slave bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = 16;

    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
    localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW + 1)'(1);
    localparam logic [c_AW:0]   c_DEPTH_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_CW-1:0] c_TIMEOUT   = c_CW'(TIMEOUT);
    localparam logic [c_CW-1:0] c_RD_LAT    = c_CW'(RD_LAT);
    localparam logic [c_CW-1:0] c_WAIT_ONE  = c_CW'(1);

    localparam logic [7:0] c_OP_RESET   = 8'h01;
    localparam logic [7:0] c_OP_EVAL    = 8'h03;
    localparam logic [7:0] c_OP_EXTRACT = 8'h04;

    localparam logic [1:0] c_KIND_DATA    = 2'd0;
    localparam logic [1:0] c_KIND_SAT     = 2'd1;
    localparam logic [1:0] c_KIND_UNSAT   = 2'd2;
    localparam logic [1:0] c_KIND_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_EVAL = 3'd2,
        ST_WAIT_RD   = 3'd3,
        ST_ABORT     = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    state_t          r_state;
    logic [7:0]      r_s_cmd;
    logic [7:0]      r_s_a;
    logic [7:0]      r_s_b;
    logic [7:0]      r_s_c;
    logic            r_rsp_valid;
    logic [1:0]      r_rsp_kind;
    logic [7:0]      r_rsp_data;
    logic [c_CW-1:0] r_cnt;

    logic [31:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_in_ready;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_head;
    logic [7:0]  w_cnt_sat;

    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_empty    = (r_count == '0);
    // Held low throughout reset so nothing is accepted into a FIFO being cleared.
    assign w_in_ready = ~w_full & ~rst;
    assign w_push     = bus.in_valid & w_in_ready;
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_cnt_sat  = (r_cnt > c_CW'(255)) ? 8'hFF : r_cnt[7:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_cmd, bus.in_a, bus.in_b, bus.in_c};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s_cmd     <= 8'h00;
            r_s_a       <= 8'h00;
            r_s_b       <= 8'h00;
            r_s_c       <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_kind  <= 2'd0;
            r_rsp_data  <= 8'h00;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_s_cmd, r_s_a, r_s_b, r_s_c} <= w_head;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    {r_s_cmd, r_s_a, r_s_b, r_s_c} <= 32'h0;
                    r_cnt <= c_WAIT_ONE;
                    if (r_s_cmd == c_OP_EVAL) begin
                        r_state <= ST_WAIT_EVAL;
                    end else if (r_s_cmd == c_OP_EXTRACT) begin
                        r_state <= ST_WAIT_RD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_EVAL: begin
                    // A flag arriving in the timeout cycle still counts as an answer.
                    if (bus.s_sat) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_kind  <= c_KIND_SAT;
                        r_rsp_data  <= w_cnt_sat;
                        r_state     <= ST_RESP;
                    end else if (bus.s_unsat) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_kind  <= c_KIND_UNSAT;
                        r_rsp_data  <= w_cnt_sat;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_s_cmd <= c_OP_RESET;
                        r_state <= ST_ABORT;
                    end else begin
                        r_cnt <= r_cnt + c_WAIT_ONE;
                    end
                end
                ST_ABORT: begin
                    r_s_cmd     <= 8'h00;
                    r_rsp_valid <= 1'b1;
                    r_rsp_kind  <= c_KIND_TIMEOUT;
                    r_rsp_data  <= 8'hFF;
                    r_state     <= ST_RESP;
                end
                ST_WAIT_RD: begin
                    if (r_cnt == c_RD_LAT) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_kind  <= c_KIND_DATA;
                        r_rsp_data  <= bus.s_exbus;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_WAIT_ONE;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state != ST_IDLE) | ~w_empty;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_kind  = r_rsp_kind;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.s_cmd     = r_s_cmd;
    assign bus.s_a       = r_s_a;
    assign bus.s_b       = r_s_b;
    assign bus.s_c       = r_s_c;
endmodule
`default_nettype wire

// File: tb/tb_sat_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sat_cmd_sequencer
// Brief    : Random host/solver stimulus against a cycle-level queue model.
// Revision : 1.0
// ============================================================================
module tb_sat_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int RD_LAT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sat_cmd_sequencer_if bus ();

    sat_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] w;
        int          pcyc;
    } ent_t;

    ent_t        fifo_q[$];
    logic [31:0] dir_q[$];
    int          plan_k[$];
    int          plan_f[$];

    // Model of the outstanding multi-cycle operation (0 none, 1 EVAL, 2 EXTRACT).
    int          op_kind    = 0;
    int          op_issue   = 0;
    int          op_k       = 0;
    int          rsp_due    = 0;
    logic [1:0]  op_flags   = 2'd0;
    logic [7:0]  op_val     = 8'h00;
    logic [1:0]  exp_kind   = 2'd0;
    logic [7:0]  exp_data   = 8'h00;
    bit          rsp_shown  = 1'b0;
    bit          stop_push  = 1'b0;
    int          free_cyc   = 0;
    int          last_issue = -10;

    function automatic logic [31:0] rand_word();
        int          sel;
        logic [7:0]  op;
        sel = int'($urandom_range(0, 9));
        if (sel <= 2)      op = 8'h03;
        else if (sel <= 4) op = 8'h04;
        else if (sel == 5) op = 8'h00;
        else if (sel == 6) op = 8'h01;
        else if (sel == 7) op = 8'h02;
        else               op = 8'($urandom_range(5, 255));
        return {op, 8'($urandom_range(1, 255)), 8'($urandom), 8'($urandom)};
    endfunction

    task automatic start_op(input logic [7:0] op);
        if (op == 8'h03) begin
            op_kind   = 1;
            op_issue  = cyc;
            rsp_shown = 1'b0;
            if (plan_k.size() > 0) begin
                op_k     = plan_k.pop_front();
                op_flags = 2'(plan_f.pop_front());
            end else begin
                op_k     = int'($urandom_range(1, TIMEOUT + 1));
                op_flags = 2'($urandom_range(1, 3));
            end
            if (op_k > TIMEOUT) begin
                rsp_due  = TIMEOUT + 2;
                exp_kind = 2'd3;
                exp_data = 8'hFF;
            end else begin
                rsp_due  = op_k + 1;
                exp_kind = op_flags[0] ? 2'd1 : 2'd2;
                exp_data = (op_k > 255) ? 8'hFF : 8'(op_k);
            end
        end else if (op == 8'h04) begin
            op_kind   = 2;
            op_issue  = cyc;
            rsp_shown = 1'b0;
            op_val    = 8'($urandom);
            rsp_due   = RD_LAT + 1;
            exp_kind  = 2'd0;
            exp_data  = op_val;
        end else begin
            free_cyc = cyc + 2;
        end
    endtask

    // One mid-cycle step: check outputs, then drive solver, response and host inputs.
    task automatic step();
        logic [31:0] obs;
        logic [31:0] nw;
        ent_t        e;
        int          off;
        int          due;
        int          lim;
        bit          nv;
        bit          nr;
        bit          from_dir;
        obs = {bus.s_cmd, bus.s_a, bus.s_b, bus.s_c};
        if (op_kind != 0) begin
            off = cyc - op_issue;
            if (op_kind == 1 && op_k > TIMEOUT && off == TIMEOUT + 1)
                check("abort_bus", obs, 32'h0100_0000);
            else
                check("bus_idle_op", obs, 32'h0);
            if (!rsp_shown) begin
                check("rsp_timing", 32'(bus.rsp_valid), 32'(off == rsp_due));
                rsp_shown = bus.rsp_valid;
            end
            if (rsp_shown) begin
                check("rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
                check("rsp_kind", 32'(bus.rsp_kind), 32'(exp_kind));
                check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
            end
        end else begin
            check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
            due = -1;
            if (fifo_q.size() > 0)
                due = (fifo_q[0].pcyc + 2 > free_cyc) ? fifo_q[0].pcyc + 2 : free_cyc;
            if (due == cyc) begin
                e = fifo_q.pop_front();
                check("issue_word", obs, e.w);
                last_issue = cyc;
                start_op(e.w[31:24]);
            end else begin
                check("bus_idle", obs, 32'h0);
            end
        end
        check("busy", 32'(bus.busy),
              32'(op_kind != 0 || fifo_q.size() != 0 || last_issue == cyc));
        check("in_ready", 32'(bus.in_ready), 32'(fifo_q.size() < DEPTH));

        // Flags stay quiet while the answer is awaited; noise everywhere else.
        off = cyc - op_issue;
        lim = (op_k < TIMEOUT) ? op_k : TIMEOUT;
        if (op_kind == 1 && off >= 1 && off <= lim) begin
            bus.s_sat   = (off == op_k) && op_flags[0];
            bus.s_unsat = (off == op_k) && op_flags[1];
        end else begin
            bus.s_sat   = 1'($urandom_range(0, 1));
            bus.s_unsat = 1'($urandom_range(0, 1));
        end
        bus.s_exbus = (op_kind == 2 && off == RD_LAT) ? op_val : 8'($urandom);

        nr = ($urandom_range(0, 9) < 6);
        bus.rsp_ready = nr;
        if (op_kind != 0 && rsp_shown && nr) begin
            op_kind  = 0;
            free_cyc = cyc + 2;
        end

        from_dir = 1'b0;
        nw       = 32'h0;
        if (stop_push) begin
            nv = 1'b0;
        end else if (dir_q.size() > 0) begin
            nv       = 1'b1;
            nw       = dir_q[0];
            from_dir = 1'b1;
        end else begin
            nv = ($urandom_range(0, 1) == 0);
            nw = rand_word();
        end
        bus.in_valid = nv;
        {bus.in_cmd, bus.in_a, bus.in_b, bus.in_c} = nw;
        if (nv && bus.in_ready) begin
            e.w    = nw;
            e.pcyc = cyc;
            fifo_q.push_back(e);
            if (from_dir) void'(dir_q.pop_front());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_cmd    = 8'h00;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.in_c      = 8'h00;
        bus.rsp_ready = 1'b0;
        bus.s_sat     = 1'b0;
        bus.s_unsat   = 1'b0;
        bus.s_exbus   = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset_s_bus", {bus.s_cmd, bus.s_a, bus.s_b, bus.s_c}, 32'h0);
        check("reset_rsp", {21'b0, bus.rsp_valid, bus.rsp_kind, bus.rsp_data}, 32'h0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        dir_q  = '{32'h02112233, 32'h03010203, 32'h030A0B0C, 32'h04A5A5A5,
                   32'h03111111, 32'h02222222, 32'h01333333, 32'h00444444,
                   32'h07555555, 32'h02666666};
        plan_k = '{5, TIMEOUT + 1, 3};
        plan_f = '{2, 0, 3};

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            step();
        end
        stop_push = 1'b1;
        n = 0;
        while ((fifo_q.size() > 0 || op_kind != 0) && n < 300) begin
            @(negedge clk);
            step();
            n++;
        end
        check("drain_done", 32'(fifo_q.size() == 0 && op_kind == 0), 32'd1);

        // Reset in the middle of an EVAL wait with two words still queued.
        bus.rsp_ready = 1'b0;
        bus.s_sat     = 1'b0;
        bus.s_unsat   = 1'b0;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1;
        {bus.in_cmd, bus.in_a, bus.in_b, bus.in_c} = 32'h03010203;
        @(negedge clk);
        {bus.in_cmd, bus.in_a, bus.in_b, bus.in_c} = 32'h02445566;
        @(negedge clk);
        check("rst_phase_issue", {bus.s_cmd, bus.s_a, bus.s_b, bus.s_c}, 32'h03010203);
        {bus.in_cmd, bus.in_a, bus.in_b, bus.in_c} = 32'h01778899;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_phase_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_s_bus", {bus.s_cmd, bus.s_a, bus.s_b, bus.s_c}, 32'h0);
        check("async_rst_rsp", {21'b0, bus.rsp_valid, bus.rsp_kind, bus.rsp_data}, 32'h0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 2 * TIMEOUT + 8; i++) begin
            @(negedge clk);
            check("post_rst_no_issue", {bus.s_cmd, bus.s_a, bus.s_b, bus.s_c}, 32'h0);
            check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("post_rst_idle", 32'(bus.busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
